// File: rtl/cs161_trace_capture.sv
// -----------------------------------------------------------------------------
// cs161_trace_capture
//
// Trace sink for the cs161_processor debug trace port. While capturing, every
// rising edge samples the retiring instruction. Records with a non-zero
// writeback register go into a show-ahead FIFO that is drained over a
// valid/ready read port. Capture stops on a PC breakpoint or when the PC has
// stayed unchanged for STALL_LIMIT consecutive compares (jump-to-self halt).
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   STALL_LIMIT  equal-PC compares that declare a halt (>= 1)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   arm                      start / restart capture (ignored while capturing)
//   stop_en, stop_pc         PC breakpoint enable and address
//   prog_count, instr_opcode,
//   write_reg_addr,
//   write_reg_data           trace port of the retiring instruction
//   rd_valid, rd_ready       read handshake for the FIFO head
//   rd_pc, rd_opcode,
//   rd_reg_addr, rd_reg_data head record fields (hold last value when empty)
//   capturing                state is CAPTURE
//   stalled, bp_hit          sticky stop-cause flags, cleared on re-arm
//   instr_count              sampling edges since the last arm (wraps)
//   drop_count               records lost to overflow (saturating)
// -----------------------------------------------------------------------------
module cs161_trace_capture #(
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        stop_en,
    input  logic [31:0] stop_pc,
    input  logic [31:0] prog_count,
    input  logic [5:0]  instr_opcode,
    input  logic [4:0]  write_reg_addr,
    input  logic [31:0] write_reg_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_pc,
    output logic [5:0]  rd_opcode,
    output logic [4:0]  rd_reg_addr,
    output logic [31:0] rd_reg_data,
    output logic        capturing,
    output logic        stalled,
    output logic        bp_hit,
    output logic [31:0] instr_count,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int RW = 75;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_capturing;
    logic            r_stalled;
    logic            r_bp_hit;
    logic [31:0]     r_instr_count;
    logic [15:0]     r_drop_count;
    logic [SW-1:0]   r_stall_cnt;
    logic [31:0]     r_prev_pc;
    logic            r_prev_valid;

    logic [RW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_rd_valid;
    logic [RW-1:0]   r_head;

    logic            w_sample;
    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push_ok;
    logic            w_drop;
    logic [CW-1:0]   w_count_next;
    logic [AW-1:0]   w_rd_ptr_next;
    logic [RW-1:0]   w_new_rec;
    logic [RW-1:0]   w_head_next;
    logic            w_pc_same;
    logic [SW-1:0]   w_stall_next;
    logic            w_stall_trip;
    logic            w_bp_trip;
    logic            w_arm_ok;

    assign w_sample      = (r_state == ST_CAPTURE);
    assign w_push_req    = w_sample && (write_reg_addr != 5'd0);
    assign w_pop         = r_rd_valid && rd_ready;
    assign w_full        = (r_count == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok     = w_push_req && (!w_full || w_pop);
    assign w_drop        = w_push_req && !w_push_ok;
    assign w_count_next  = r_count + CW'(w_push_ok) - CW'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    assign w_new_rec     = {prog_count, instr_opcode, write_reg_addr, write_reg_data};

    // The first sample after arm has no previous PC, so it never counts as equal.
    assign w_pc_same     = r_prev_valid && (prog_count == r_prev_pc);
    assign w_stall_next  = w_pc_same ? (r_stall_cnt + SW'(1)) : {SW{1'b0}};
    assign w_stall_trip  = w_sample && (w_stall_next == SW'(STALL_LIMIT));
    assign w_bp_trip     = w_sample && stop_en && (prog_count == stop_pc);
    assign w_arm_ok      = arm && (r_state != ST_CAPTURE);

    // Next head record: the new entry when it lands on the slot becoming the
    // head, otherwise the stored slot; held unchanged when the FIFO goes empty.
    always_comb begin
        w_head_next = r_head;
        if (w_count_next != {CW{1'b0}}) begin
            if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) begin
                w_head_next = w_new_rec;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end else begin
            w_head_next = r_head;
        end
    end

    // Capture state machine, stop-cause flags, counters and stall tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_capturing   <= 1'b0;
            r_stalled     <= 1'b0;
            r_bp_hit      <= 1'b0;
            r_instr_count <= 32'd0;
            r_drop_count  <= 16'd0;
            r_stall_cnt   <= {SW{1'b0}};
            r_prev_pc     <= 32'd0;
            r_prev_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state     <= ST_CAPTURE;
                        r_capturing <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (w_stall_trip || w_bp_trip) begin
                        r_state     <= ST_STOPPED;
                        r_capturing <= 1'b0;
                    end else begin
                        r_state     <= ST_CAPTURE;
                    end
                end
                ST_STOPPED: begin
                    if (arm) begin
                        r_state     <= ST_CAPTURE;
                        r_capturing <= 1'b1;
                    end else begin
                        r_state     <= ST_STOPPED;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_capturing <= 1'b0;
                end
            endcase

            // Arm and sampling are exclusive: arm is only honoured outside CAPTURE.
            if (w_arm_ok) begin
                r_stalled     <= 1'b0;
                r_bp_hit      <= 1'b0;
                r_instr_count <= 32'd0;
                r_drop_count  <= 16'd0;
                r_stall_cnt   <= {SW{1'b0}};
                r_prev_valid  <= 1'b0;
            end else if (w_sample) begin
                r_instr_count <= r_instr_count + 32'd1;
                r_stall_cnt   <= w_stall_next;
                r_prev_pc     <= prog_count;
                r_prev_valid  <= 1'b1;
                if (w_stall_trip) begin
                    r_stalled <= 1'b1;
                end else begin
                    r_stalled <= r_stalled;
                end
                if (w_bp_trip) begin
                    r_bp_hit <= 1'b1;
                end else begin
                    r_bp_hit <= r_bp_hit;
                end
                if (w_drop && (r_drop_count != 16'hFFFF)) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end else begin
                    r_drop_count <= r_drop_count;
                end
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    // FIFO pointers, occupancy and the registered show-ahead head record.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_rd_valid <= 1'b0;
            r_head     <= {RW{1'b0}};
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_push_ok);
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_rd_valid <= (w_count_next != {CW{1'b0}});
            r_head     <= w_head_next;
        end
    end

    // Record storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_new_rec;
        end
    end

    assign rd_valid    = r_rd_valid;
    assign rd_pc       = r_head[74:43];
    assign rd_opcode   = r_head[42:37];
    assign rd_reg_addr = r_head[36:32];
    assign rd_reg_data = r_head[31:0];
    assign capturing   = r_capturing;
    assign stalled     = r_stalled;
    assign bp_hit      = r_bp_hit;
    assign instr_count = r_instr_count;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_cs161_trace_capture.sv
module tb_cs161_trace_capture;

    localparam int DEPTH       = 16;
    localparam int STALL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        stop_en;
    logic [31:0] stop_pc;
    logic [31:0] prog_count;
    logic [5:0]  instr_opcode;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [5:0]  rd_opcode;
    logic [4:0]  rd_reg_addr;
    logic [31:0] rd_reg_data;
    logic        capturing;
    logic        stalled;
    logic        bp_hit;
    logic [31:0] instr_count;
    logic [15:0] drop_count;

    cs161_trace_capture #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop_en(stop_en), .stop_pc(stop_pc),
        .prog_count(prog_count), .instr_opcode(instr_opcode),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_opcode(rd_opcode), .rd_reg_addr(rd_reg_addr), .rd_reg_data(rd_reg_data),
        .capturing(capturing), .stalled(stalled), .bp_hit(bp_hit),
        .instr_count(instr_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pops = 0;

    // Scoreboard: records the reference model says the FIFO holds, oldest first.
    logic [74:0] exp_q[$];

    typedef enum int {M_IDLE, M_CAP, M_STOP} mstate_t;
    mstate_t     m_state;
    logic [31:0] m_instr;
    int          m_drop;
    bit          m_stalled;
    bit          m_bp;
    bit          m_have_prev;
    logic [31:0] m_prev_pc;
    int          m_run;

    task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state     = M_IDLE;
        m_instr     = 32'd0;
        m_drop      = 0;
        m_stalled   = 1'b0;
        m_bp        = 1'b0;
        m_have_prev = 1'b0;
        m_prev_pc   = 32'd0;
        m_run       = 0;
        exp_q.delete();
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_edge();
        int sz;
        bit pop;
        bit stop;
        sz   = exp_q.size();
        pop  = (sz > 0) && rd_ready;
        stop = 1'b0;
        if (m_state == M_CAP) begin
            m_instr = m_instr + 32'd1;
            if (write_reg_addr != 5'd0) begin
                if (sz < DEPTH || pop)
                    exp_q.push_back({prog_count, instr_opcode, write_reg_addr, write_reg_data});
                else if (m_drop < 65535)
                    m_drop++;
            end
            if (m_have_prev) begin
                if (prog_count == m_prev_pc) m_run++;
                else m_run = 0;
            end
            m_prev_pc   = prog_count;
            m_have_prev = 1'b1;
            if (m_run == STALL_LIMIT) begin
                m_stalled = 1'b1;
                stop = 1'b1;
            end
            if (stop_en && prog_count == stop_pc) begin
                m_bp = 1'b1;
                stop = 1'b1;
            end
            if (stop) m_state = M_STOP;
        end else if (arm) begin
            m_state     = M_CAP;
            m_instr     = 32'd0;
            m_drop      = 0;
            m_stalled   = 1'b0;
            m_bp        = 1'b0;
            m_run       = 0;
            m_have_prev = 1'b0;
        end
    endtask

    task automatic check_status();
        logic [15:0] d;
        d = m_drop[15:0];
        chk("capturing",   capturing,   (m_state == M_CAP));
        chk("stalled",     stalled,     m_stalled);
        chk("bp_hit",      bp_hit,      m_bp);
        chk("instr_count", instr_count, m_instr);
        chk("drop_count",  drop_count,  d);
        chk("rd_valid",    rd_valid,    (exp_q.size() != 0));
    endtask

    // One clock: apply inputs, predict, let the edge pass, compare status.
    task automatic cycle(input bit a, input logic [31:0] pc, input logic [4:0] ra,
                         input logic [31:0] rdat, input bit rdy);
        arm            = a;
        prog_count     = pc;
        write_reg_addr = ra;
        write_reg_data = rdat;
        instr_opcode   = 6'($urandom);
        rd_ready       = rdy;
        model_edge();
        @(posedge clk);
        #1;
        arm = 1'b0;
        check_status();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'hF000 + 32'(k * 4), 5'd0, 32'd0, 1'b1);
    endtask

    // Monitor: every completed handshake must match the oldest expected record.
    always @(negedge clk) begin
        if (rst && rd_valid && rd_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL record: got pc=%0h data=%0h expected no record", rd_pc, rd_reg_data);
            end else begin
                chk("record", {rd_pc, rd_opcode, rd_reg_addr, rd_reg_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [31:0] pc;
        rst = 1'b0; arm = 1'b0; stop_en = 1'b0; stop_pc = 32'd0; prog_count = 32'd0;
        instr_opcode = 6'd0; write_reg_addr = 5'd0; write_reg_data = 32'd0; rd_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_rd_fields", {rd_pc, rd_opcode, rd_reg_addr, rd_reg_data}, 75'd0);
        check_status();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'(i * 4), 5'd1, 32'd7, 1'b1);

        // Five writebacks $8..$12, breakpoint on the last one.
        stop_en = 1'b1; stop_pc = 32'h10; p0 = n_pops;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'(i * 4), 5'(8 + i), 32'(16 + i), 1'b1);
        drain(3);
        chk("A_instr_count", instr_count, 32'd5);
        chk("A_pops", 32'(n_pops - p0), 32'd5);
        chk("A_drop_count", drop_count, 16'd0);

        // Three of six instructions write $0.
        stop_pc = 32'h114; p0 = n_pops;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 32'h100 + 32'(i * 4), (i % 2 == 1) ? 5'd0 : 5'(1 + i), $urandom, 1'b1);
        drain(3);
        chk("B_instr_count", instr_count, 32'd6);
        chk("B_pops", 32'(n_pops - p0), 32'd3);

        // Overflow: 20 writebacks into 16 entries with the reader stalled.
        stop_pc = 32'h300 + 32'(19 * 4); p0 = n_pops;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h300 + 32'(i * 4), 5'(1 + i), $urandom, 1'b0);
        chk("C_drop_count", drop_count, 16'd4);
        drain(20);
        chk("C_pops", 32'(n_pops - p0), 32'd16);

        // Full FIFO with simultaneous push and pop across pointer wrap.
        stop_pc = 32'h400 + 32'(39 * 4); p0 = n_pops;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 40; i++)
            cycle(1'b0, 32'h400 + 32'(i * 4), 5'(1 + (i % 31)), $urandom, (i >= 16));
        chk("D_drop_count", drop_count, 16'd0);
        drain(20);
        chk("D_pops", 32'(n_pops - p0), 32'd40);

        // Jump-to-self halt at 0x24.
        stop_en = 1'b0;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 32'h1C, 5'd4, 32'hA1, 1'b1);
        cycle(1'b0, 32'h20, 5'd5, 32'hA2, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h24, 5'd6, 32'(32'hB0 + i), 1'b1);
        chk("E_stalled", stalled, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h28 + 32'(i * 4), 5'd7, 32'hC0, 1'b1);
        cycle(1'b1, 32'h40, 5'd0, 32'd0, 1'b1);
        chk("E_rearm_stalled", stalled, 1'b0);
        chk("E_rearm_count", instr_count, 32'd0);

        // Breakpoint at 0x8 with $3 = 0xDEAD still captured.
        stop_en = 1'b1; stop_pc = 32'h8;
        cycle(1'b0, 32'h0, 5'd1, 32'h11, 1'b1);
        cycle(1'b0, 32'h4, 5'd2, 32'h22, 1'b1);
        cycle(1'b0, 32'h8, 5'd3, 32'hDEAD, 1'b1);
        chk("F_bp_hit", bp_hit, 1'b1);
        chk("F_head_data", rd_reg_data, 32'hDEAD);
        drain(3);

        // Randomized traffic, including repeated PCs, random arm and breakpoints.
        stop_pc = 32'h5A0; pc = 32'h500;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) pc = 32'h500 + 32'($urandom_range(0, 63) * 4);
            cycle(($urandom_range(0, 11) == 0), pc,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, ($urandom_range(0, 2) != 0));
        end

        // Force a stop, drain, then reset with 7 records buffered.
        stop_pc = 32'h700;
        cycle(1'b0, 32'h700, 5'd0, 32'd0, 1'b1);
        drain(20);
        stop_en = 1'b0;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 32'h800 + 32'(i * 4), 5'(9 + i), $urandom, 1'b0);
        rst = 1'b0;
        #1;
        chk("H_rst_rd_valid", rd_valid, 1'b0);
        chk("H_rst_count", instr_count, 32'd0);
        chk("H_rst_flags", {capturing, stalled, bp_hit}, 3'd0);
        model_reset();
        check_status();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h900 + 32'(i * 4), 5'd2, 32'h55, 1'b1);
        chk("H_noarm_count", instr_count, 32'd0);
        stop_en = 1'b1; stop_pc = 32'hA08;
        cycle(1'b1, 32'h0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'hA00 + 32'(i * 4), 5'd20, $urandom, 1'b1);
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
